// File: rtl/pin_drive_pkg.sv
// ============================================================================
// Module  : pin_drive_pkg
// Purpose : Shared state encoding and default hold length for the pin driver.
// Contents: c_HOLD_CYC_DEF - default number of cycles a new pin level is held
//           c_CNT_W        - hold counter width
//           pd_state_t     - STABLE / HOLD state encoding
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pin_drive_pkg;

    localparam int unsigned c_HOLD_CYC_DEF = 16;
    localparam int          c_CNT_W        = 16;

    // HOLD is encoded as 1 so the busy indication is the state flop itself.
    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_HOLD   = 1'b1
    } pd_state_t;

endpackage

`default_nettype wire

// File: rtl/hold_timer.sv
// ============================================================================
// Module  : hold_timer
// Purpose : Loadable down-counter that saturates at zero.
// Ports   : CLK, RSTn      - clock, asynchronous active-low reset
//           load, load_val - load the counter (priority over enable)
//           en             - decrement by one (ignored when count is zero)
//           count          - registered counter value
//           zero           - count equals zero
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_timer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            // Guarded so the counter can never wrap below zero.
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pin_drive_module.sv
// ============================================================================
// Module  : pin_drive_module
// Purpose : Drives a pin high/low on request and holds every new level for at
//           least HOLD_CYC cycles. One opposite request may be queued while a
//           hold is running; conflicting or excess requests pulse Err_Sig.
// Ports   : CLK, RSTn  - clock, asynchronous active-low reset
//           H2L_Req    - request to drive the pin low
//           L2H_Req    - request to drive the pin high
//           Pin_Out    - registered pin level, idles high
//           Busy_Sig   - hold period running
//           Done_Sig   - one-cycle pulse at the end of a hold period
//           Err_Sig    - one-cycle pulse on a conflicting or dropped request
//           SQ_Count   - hold counter value (simulation visibility)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import pin_drive_pkg::*;

module pin_drive_module #(
    parameter int unsigned HOLD_CYC = c_HOLD_CYC_DEF
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               H2L_Req,
    input  logic               L2H_Req,
    output logic               Pin_Out,
    output logic               Busy_Sig,
    output logic               Done_Sig,
    output logic               Err_Sig,
    output logic [c_CNT_W-1:0] SQ_Count
);

    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(HOLD_CYC - 1);

    pd_state_t          r_state, w_state_nxt;
    logic               r_pin,   w_pin_nxt;
    logic               r_pend,  w_pend_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_err,   w_err_nxt;
    logic               w_load;
    logic               w_en;
    logic               w_zero;
    logic [c_CNT_W-1:0] w_count;
    logic               w_conflict;
    logic               w_opp;

    // Both requests together cancel each other; otherwise only a request for
    // the level the pin is not already at counts as work.
    assign w_conflict = H2L_Req & L2H_Req;
    assign w_opp      = ~w_conflict & (r_pin ? H2L_Req : L2H_Req);

    hold_timer #(
        .WIDTH (c_CNT_W)
    ) u_hold_timer (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .load     (w_load),
        .load_val (c_RELOAD),
        .en       (w_en),
        .count    (w_count),
        .zero     (w_zero)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_STABLE;
            r_pin   <= 1'b1;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pin   <= w_pin_nxt;
            r_pend  <= w_pend_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pin_nxt   = r_pin;
        w_pend_nxt  = r_pend;
        w_done_nxt  = 1'b0;
        w_err_nxt   = w_conflict;
        w_load      = 1'b0;
        w_en        = 1'b0;

        case (r_state)
            ST_STABLE: begin
                if (w_opp) begin
                    w_pin_nxt   = ~r_pin;
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_zero) begin
                    // Final hold cycle: a request arriving now is handled the
                    // same as one already queued.
                    w_done_nxt = 1'b1;
                    if (r_pend || w_opp) begin
                        w_pin_nxt  = ~r_pin;
                        w_load     = 1'b1;
                        w_pend_nxt = 1'b0;
                        if (r_pend && w_opp) begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_STABLE;
                    end
                end else begin
                    w_en = 1'b1;
                    if (w_opp) begin
                        if (r_pend) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_pend_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign Pin_Out  = r_pin;
    assign Busy_Sig = (r_state == ST_HOLD);
    assign Done_Sig = r_done;
    assign Err_Sig  = r_err;
    assign SQ_Count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_pin_drive_module.sv
// ============================================================================
// Module  : tb_pin_drive_module
// Purpose : Self-checking bench for pin_drive_module with HOLD_CYC = 4.
//           Directed scenarios push expected outputs into a scoreboard queue
//           as stimulus is driven; a random loopback run counts edge-detector
//           pulses against observed pin toggles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pin_drive_module;

    localparam int unsigned c_HOLD = 4;

    logic        CLK;
    logic        RSTn;
    logic        H2L_Req;
    logic        L2H_Req;
    logic        Pin_Out;
    logic        Busy_Sig;
    logic        Done_Sig;
    logic        Err_Sig;
    logic [15:0] SQ_Count;

    typedef struct {
        string       tag;
        logic        pin;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Loopback edge detector state.
    logic r_lb_prev;
    int   det_cnt  = 0;
    int   toggles  = 0;

    pin_drive_module #(
        .HOLD_CYC (c_HOLD)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .H2L_Req  (H2L_Req),
        .L2H_Req  (L2H_Req),
        .Pin_Out  (Pin_Out),
        .Busy_Sig (Busy_Sig),
        .Done_Sig (Done_Sig),
        .Err_Sig  (Err_Sig),
        .SQ_Count (SQ_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) r_lb_prev <= Pin_Out;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of requests (called at a negedge), queue the outputs
    // expected after the next rising edge, then compare at the next negedge.
    task automatic drive(input logic h, input logic l,
                         input logic e_pin, input logic e_busy,
                         input logic e_done, input logic e_err,
                         input logic [15:0] e_cnt, input string tag);
        exp_t e;
        H2L_Req = h;
        L2H_Req = l;
        e.tag  = tag;
        e.pin  = e_pin;
        e.busy = e_busy;
        e.done = e_done;
        e.err  = e_err;
        e.cnt  = e_cnt;
        sb_q.push_back(e);
        @(negedge CLK);
        H2L_Req = 1'b0;
        L2H_Req = 1'b0;
        e = sb_q.pop_front();
        check_val({e.tag, ".pin"},  32'(Pin_Out),  32'(e.pin));
        check_val({e.tag, ".busy"}, 32'(Busy_Sig), 32'(e.busy));
        check_val({e.tag, ".done"}, 32'(Done_Sig), 32'(e.done));
        check_val({e.tag, ".err"},  32'(Err_Sig),  32'(e.err));
        check_val({e.tag, ".cnt"},  32'(SQ_Count), 32'(e.cnt));
    endtask

    // One full isolated hold period started by a single request.
    task automatic hold_run(input logic h, input logic l, input logic np, input string tag);
        drive(h, l, np, 1, 0, 0, 3, {tag, "0"});
        drive(0, 0, np, 1, 0, 0, 2, {tag, "1"});
        drive(0, 0, np, 1, 0, 0, 1, {tag, "2"});
        drive(0, 0, np, 1, 0, 0, 0, {tag, "3"});
        drive(0, 0, np, 0, 1, 0, 0, {tag, "4"});
        drive(0, 0, np, 0, 0, 0, 0, {tag, "5"});
    endtask

    initial begin
        logic lb_last;
        int   run;
        bit   seen_first;

        RSTn    = 1'b0;
        H2L_Req = 1'b0;
        L2H_Req = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst.pin",  32'(Pin_Out),  32'd1);
        check_val("rst.busy", 32'(Busy_Sig), 32'd0);
        check_val("rst.done", 32'(Done_Sig), 32'd0);
        check_val("rst.err",  32'(Err_Sig),  32'd0);
        check_val("rst.cnt",  32'(SQ_Count), 32'd0);
        RSTn = 1'b1;

        // Request on the first edge after release; basic hold timeline.
        hold_run(1, 0, 0, "s1_");

        // Same-level while low is ignored, then return high.
        drive(1, 0, 0, 0, 0, 0, 0, "same_lo");
        hold_run(0, 1, 1, "back_hi");

        // Queued opposite request: two back-to-back holds.
        drive(1, 0, 0, 1, 0, 0, 3, "pend0");
        drive(0, 0, 0, 1, 0, 0, 2, "pend1");
        drive(0, 1, 0, 1, 0, 0, 1, "pend2");
        drive(0, 0, 0, 1, 0, 0, 0, "pend3");
        drive(0, 0, 1, 1, 1, 0, 3, "pend4");
        drive(0, 0, 1, 1, 0, 0, 2, "pend5");
        drive(0, 0, 1, 1, 0, 0, 1, "pend6");
        drive(0, 0, 1, 1, 0, 0, 0, "pend7");
        drive(0, 0, 1, 0, 1, 0, 0, "pend8");
        drive(0, 0, 1, 0, 0, 0, 0, "pend9");

        // Conflict while stable high.
        drive(1, 1, 1, 0, 0, 1, 0, "conf0");
        drive(0, 0, 1, 0, 0, 0, 0, "conf1");

        // Same-level while high, then a third request while pending is dropped.
        drive(0, 1, 1, 0, 0, 0, 0, "same_hi");
        drive(1, 0, 0, 1, 0, 0, 3, "drop0");
        drive(0, 1, 0, 1, 0, 0, 2, "drop1");
        drive(0, 1, 0, 1, 0, 1, 1, "drop2");
        drive(0, 0, 0, 1, 0, 0, 0, "drop3");
        drive(0, 0, 1, 1, 1, 0, 3, "drop4");
        drive(0, 0, 1, 1, 0, 0, 2, "drop5");
        drive(0, 0, 1, 1, 0, 0, 1, "drop6");
        drive(0, 0, 1, 1, 0, 0, 0, "drop7");
        drive(0, 0, 1, 0, 1, 0, 0, "drop8");
        drive(0, 0, 1, 0, 0, 0, 0, "drop9");

        // Conflict during a hold queues nothing; same-level in hold is silent.
        drive(1, 0, 0, 1, 0, 0, 3, "hconf0");
        drive(1, 1, 0, 1, 0, 1, 2, "hconf1");
        drive(1, 0, 0, 1, 0, 0, 1, "hconf2");
        drive(0, 0, 0, 1, 0, 0, 0, "hconf3");
        drive(0, 0, 0, 0, 1, 0, 0, "hconf4");
        drive(0, 0, 0, 0, 0, 0, 0, "hconf5");

        // Request in the final hold cycle is applied at the done edge.
        drive(0, 1, 1, 1, 0, 0, 3, "fin0");
        drive(0, 0, 1, 1, 0, 0, 2, "fin1");
        drive(0, 0, 1, 1, 0, 0, 1, "fin2");
        drive(0, 0, 1, 1, 0, 0, 0, "fin3");
        drive(1, 0, 0, 1, 1, 0, 3, "fin4");
        drive(0, 0, 0, 1, 0, 0, 2, "fin5");
        drive(0, 0, 0, 1, 0, 0, 1, "fin6");
        drive(0, 0, 0, 1, 0, 0, 0, "fin7");
        drive(0, 0, 0, 0, 1, 0, 0, "fin8");
        drive(0, 0, 0, 0, 0, 0, 0, "fin9");
        hold_run(0, 1, 1, "back_hi2");

        // Asynchronous reset in the middle of a hold at counter 2.
        drive(1, 0, 0, 1, 0, 0, 3, "mrst0");
        drive(0, 0, 0, 1, 0, 0, 2, "mrst1");
        RSTn = 1'b0;
        #1;
        check_val("mrst.pin",  32'(Pin_Out),  32'd1);
        check_val("mrst.busy", 32'(Busy_Sig), 32'd0);
        check_val("mrst.cnt",  32'(SQ_Count), 32'd0);
        check_val("mrst.done", 32'(Done_Sig), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_val("mrst.nodone", 32'(Done_Sig), 32'd0);
            check_val("mrst.idle",   32'(Busy_Sig), 32'd0);
        end
        RSTn = 1'b1;
        @(negedge CLK);

        // Random loopback run.
        lb_last    = Pin_Out;
        run        = 0;
        seen_first = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (Pin_Out !== r_lb_prev) det_cnt++;
            if (Pin_Out !== lb_last) begin
                toggles++;
                if (seen_first) check_val("lb.persist", 32'(run >= int'(c_HOLD)), 32'd1);
                seen_first = 1'b1;
                run        = 1;
                lb_last    = Pin_Out;
            end else begin
                run++;
            end
            H2L_Req = ($urandom_range(0, 2) == 0);
            L2H_Req = ~H2L_Req & ($urandom_range(0, 2) == 0);
            @(negedge CLK);
        end
        H2L_Req = 1'b0;
        L2H_Req = 1'b0;
        check_val("lb.det_vs_toggle", 32'(det_cnt), 32'(toggles));
        check_val("lb.toggled",       32'(toggles > 10), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pin_drive_module.md
PIN_DRIVE_MODULE -- requirements
Module: pin_drive_module

Interface
REQ-001 HOLD_CYC, default 16, minimum number of cycles Pin_Out holds a new level after each edge; legal range 2..65535.
REQ-002 CLK  input  1  single system clock; all logic on rising edge.
REQ-003 RSTn  input  1  asynchronous, active-low reset.
REQ-004 H2L_Req  input  1  one-cycle request to drive Pin_Out from high to low.
REQ-005 L2H_Req  input  1  one-cycle request to drive Pin_Out from low to high.
REQ-006 Pin_Out  output  1  registered, glitch-free pin level; idles high.
REQ-007 Busy_Sig  output  1  high while a hold period is running.
REQ-008 Done_Sig  output  1  one-cycle pulse when a hold period completes.
REQ-009 Err_Sig  output  1  one-cycle pulse on a conflicting or dropped request.
REQ-010 SQ_Count  output  16  hold counter value, for simulation only.

Function
REQ-011 States SHALL be STABLE and HOLD; reset state is STABLE.
REQ-012 In STABLE, a request opposite to the current Pin_Out level sampled at edge t SHALL toggle Pin_Out at edge t+1, load the counter with HOLD_CYC-1, and enter HOLD.
REQ-013 A request equal to the current Pin_Out level (H2L while low, L2H while high) SHALL be ignored silently, in any state.
REQ-014 H2L_Req and L2H_Req high in the same cycle SHALL both be discarded, with Err_Sig pulsed one cycle later.
REQ-015 In HOLD the counter SHALL decrement once per cycle and Pin_Out SHALL not change; Pin_Out therefore holds each new level for exactly HOLD_CYC cycles minimum.
REQ-016 Busy_Sig SHALL be high on exactly the cycles where the state is HOLD.
REQ-017 An opposite-level request received during HOLD SHALL set a one-deep pending flag; a second opposite request while pending is set SHALL be dropped and pulse Err_Sig.
REQ-018 When the counter is 0 in HOLD, the next edge SHALL pulse Done_Sig.
REQ-019 At that same edge, without a pending request, the state SHALL return to STABLE.
REQ-020 At that same edge, with a pending request, Pin_Out SHALL toggle, the counter SHALL reload HOLD_CYC-1, the pending flag SHALL clear, and the state SHALL stay HOLD (Busy_Sig stays high).
REQ-021 A request arriving in the final HOLD cycle (counter 0) SHALL be treated as pending and applied per REQ-020.
REQ-022 The counter SHALL be 16 bits wide, SHALL never wrap below 0, and SHALL read 0 in STABLE.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-024 Asserting RSTn low SHALL immediately force Pin_Out=1, Busy_Sig=0, Done_Sig=0, Err_Sig=0, counter=0, pending=0 and state STABLE, including mid-HOLD.
REQ-025 A request sampled on the first edge after reset release SHALL be processed normally.

Structure
REQ-026 The state encoding and the HOLD_CYC default SHALL reside in the shared package pin_drive_pkg.
REQ-027 The counter SHALL be a sub-module hold_timer with inputs load, load value and enable, and outputs count and zero flag.
REQ-028 The block SHALL pair with the existing edge detector, so that looping Pin_Out back to its input yields exactly one H2L or L2H detection per toggle.

Verification (HOLD_CYC=4)
REQ-029 Reset scenario: after reset, H2L_Req pulse at cycle 0 -> Pin_Out=0 from cycle 1; Busy_Sig high cycles 1-4; Done_Sig pulse cycle 5; Busy_Sig low from cycle 5.
REQ-030 Pending scenario: H2L_Req at cycle 0, then L2H_Req at cycle 2 -> Pin_Out low cycles 1-4, high from cycle 5; Done_Sig pulses at cycles 5 and 9; Busy_Sig continuous over cycles 1-8.
REQ-031 Conflict scenario: H2L_Req and L2H_Req together while STABLE high -> Pin_Out stays 1; Err_Sig pulses next cycle.
REQ-032 Same-level scenario: L2H_Req while Pin_Out=1 -> no change, no Err_Sig; a third request while pending is set -> Err_Sig pulse, request dropped.
REQ-033 Reset scenario: RSTn low mid-HOLD at counter 2 -> Pin_Out=1 and Busy_Sig=0 immediately, with no Done_Sig pulse.
REQ-034 Loopback scenario: random legal requests with Pin_Out looped into the edge detector -> detector pulse count equals toggle count, and each level persists at least 4 cycles.
